// File: rtl/dual_port_ram.sv
// True dual-port RAM: two independent read/write ports on one clock sharing one array.
// Registered read data, read-before-write across ports, port 1 wins a write-write collision.
module dual_port_ram #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned ADDR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en1,
    input  logic                  en2,
    input  logic                  rd_en1,
    input  logic                  rd_en2,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [ADDR_WIDTH-1:0] addr2,
    input  logic [WIDTH-1:0]      data_in1,
    input  logic [WIDTH-1:0]      data_in2,
    output logic [WIDTH-1:0]      data_out1,
    output logic [WIDTH-1:0]      data_out2
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [WIDTH-1:0] data_out1_q, data_out1_d;
    logic [WIDTH-1:0] data_out2_q, data_out2_d;

    logic wr1, wr2, rd1, rd2;
    logic in_range1, in_range2;

    assign wr1 = en1 & ~rd_en1;
    assign wr2 = en2 & ~rd_en2;
    assign rd1 = en1 & rd_en1;
    assign rd2 = en2 & rd_en2;

    // Only reachable when DEPTH is not a power of two.
    assign in_range1 = (32'(addr1) < DEPTH);
    assign in_range2 = (32'(addr2) < DEPTH);

    // Port 1 has priority on a same-address write; out-of-range writes match no word.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
            if (wr1 && (addr1 == ADDR_WIDTH'(i))) begin
                mem_d[i] = data_in1;
            end else if (wr2 && (addr2 == ADDR_WIDTH'(i))) begin
                mem_d[i] = data_in2;
            end
        end
    end

    // Reads come from mem_q, so a read colliding with a write returns the old word.
    always_comb begin
        data_out1_d = data_out1_q;
        if (rd1) begin
            data_out1_d = in_range1 ? mem_q[addr1] : '0;
        end
    end

    always_comb begin
        data_out2_d = data_out2_q;
        if (rd2) begin
            data_out2_d = in_range2 ? mem_q[addr2] : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            data_out1_q <= '0;
            data_out2_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            data_out1_q <= data_out1_d;
            data_out2_q <= data_out2_d;
        end
    end

    assign data_out1 = data_out1_q;
    assign data_out2 = data_out2_q;

endmodule

// File: tb/tb_dual_port_ram.sv
// Scoreboard bench for dual_port_ram: expected read data is queued at issue time and
// popped by a monitor one edge later; reset and hold behaviour are checked directly.
module tb_dual_port_ram;

    logic       clk;
    logic       rst_n;
    logic       en1, en2, rd_en1, rd_en2;
    logic [3:0] addr1, addr2;
    logic [7:0] data_in1, data_in2;
    logic [7:0] data_out1, data_out2;

    int total;
    int bad;

    logic [7:0] exp_q1 [$];
    logic [7:0] exp_q2 [$];
    logic       rd_v1, rd_v2;

    dual_port_ram #(
        .WIDTH(8),
        .DEPTH(16)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en1      (en1),
        .en2      (en2),
        .rd_en1   (rd_en1),
        .rd_en2   (rd_en2),
        .addr1    (addr1),
        .addr2    (addr2),
        .data_in1 (data_in1),
        .data_in2 (data_in2),
        .data_out1(data_out1),
        .data_out2(data_out2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // A read issued on this edge presents its data from this edge on.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_v1 <= 1'b0;
            rd_v2 <= 1'b0;
        end else begin
            rd_v1 <= en1 & rd_en1;
            rd_v2 <= en2 & rd_en2;
        end
    end

    always @(negedge clk) begin
        logic [7:0] e;
        if (rd_v1) begin
            total++;
            if (exp_q1.size() == 0) begin
                bad++;
                $display("FAIL port1_read: got %02h but no expected value queued", data_out1);
            end else begin
                e = exp_q1.pop_front();
                if (data_out1 !== e) begin
                    bad++;
                    $display("FAIL port1_read: got %02h want %02h", data_out1, e);
                end
            end
        end
        if (rd_v2) begin
            total++;
            if (exp_q2.size() == 0) begin
                bad++;
                $display("FAIL port2_read: got %02h but no expected value queued", data_out2);
            end else begin
                e = exp_q2.pop_front();
                if (data_out2 !== e) begin
                    bad++;
                    $display("FAIL port2_read: got %02h want %02h", data_out2, e);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %02h want %02h", name, got, want);
        end
    endtask

    // One cycle of stimulus per port; a read pushes its expected data. Reads drive data_in to Z.
    task automatic op(input logic e1, input logic r1, input logic [3:0] a1,
                      input logic [7:0] d1,
                      input logic e2, input logic r2, input logic [3:0] a2,
                      input logic [7:0] d2);
        @(negedge clk);
        en1    = e1;
        rd_en1 = r1;
        addr1  = a1;
        en2    = e2;
        rd_en2 = r2;
        addr2  = a2;
        if (e1 && r1) begin
            data_in1 = 8'hzz;
            exp_q1.push_back(d1);
        end else begin
            data_in1 = d1;
        end
        if (e2 && r2) begin
            data_in2 = 8'hzz;
            exp_q2.push_back(d2);
        end else begin
            data_in2 = d2;
        end
    endtask

    task automatic idle();
        op(1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 4'd0, 8'h00);
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        en1      = 1'b0;
        en2      = 1'b0;
        rd_en1   = 1'b0;
        rd_en2   = 1'b0;
        addr1    = '0;
        addr2    = '0;
        data_in1 = '0;
        data_in2 = '0;
        rst_n    = 1'b0;
        #12;
        chk("reset_out1", data_out1, 8'h00);
        chk("reset_out2", data_out2, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        // Load aa at addr 0 and read it so data_out1 holds aa before the mid-run reset.
        op(1'b1, 1'b0, 4'd0, 8'haa, 1'b0, 1'b0, 4'd0, 8'h00);
        op(1'b1, 1'b1, 4'd0, 8'haa, 1'b0, 1'b0, 4'd0, 8'h00);
        idle();
        chk("pre_reset_out1", data_out1, 8'haa);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_out1", data_out1, 8'h00);
        chk("async_reset_out2", data_out2, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            op(1'b1, 1'b1, 4'(i), 8'h00, 1'b1, 1'b1, 4'(15 - i), 8'h00);
        end

        op(1'b1, 1'b0, 4'd0, 8'haa, 1'b1, 1'b0, 4'd1, 8'h12);
        op(1'b1, 1'b0, 4'd2, 8'hf1, 1'b1, 1'b0, 4'd3, 8'h3a);
        op(1'b1, 1'b0, 4'd4, 8'h56, 1'b1, 1'b0, 4'd5, 8'h5a);
        op(1'b1, 1'b0, 4'd6, 8'h8f, 1'b1, 1'b0, 4'd7, 8'h14);
        op(1'b1, 1'b1, 4'd0, 8'haa, 1'b1, 1'b1, 4'd1, 8'h12);
        op(1'b1, 1'b1, 4'd2, 8'hf1, 1'b1, 1'b1, 4'd3, 8'h3a);
        op(1'b1, 1'b1, 4'd4, 8'h56, 1'b1, 1'b1, 4'd5, 8'h5a);
        op(1'b1, 1'b1, 4'd6, 8'h8f, 1'b1, 1'b1, 4'd7, 8'h14);

        // Hold: port 1 disabled with a new address, port 2 writes.
        op(1'b0, 1'b1, 4'd3, 8'h00, 1'b1, 1'b0, 4'd10, 8'h55);
        idle();
        chk("hold_out1", data_out1, 8'h8f);
        chk("hold_out2", data_out2, 8'h14);

        op(1'b1, 1'b0, 4'd9, 8'h11, 1'b1, 1'b0, 4'd9, 8'h22);
        op(1'b1, 1'b1, 4'd9, 8'h11, 1'b1, 1'b1, 4'd9, 8'h11);

        op(1'b1, 1'b0, 4'd4, 8'h77, 1'b1, 1'b1, 4'd4, 8'h56);
        op(1'b1, 1'b1, 4'd10, 8'h55, 1'b1, 1'b1, 4'd4, 8'h77);

        op(1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 1'b0, 4'd0, 8'h01);
        op(1'b1, 1'b0, 4'd15, 8'hff, 1'b0, 1'b0, 4'd0, 8'h00);
        op(1'b1, 1'b1, 4'd15, 8'hff, 1'b1, 1'b1, 4'd0, 8'h01);
        op(1'b1, 1'b1, 4'd0, 8'h01, 1'b1, 1'b1, 4'd15, 8'hff);

        idle();
        idle();
        total++;
        if (exp_q1.size() != 0 || exp_q2.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d/%0d unconsumed reads want 0/0",
                     exp_q1.size(), exp_q2.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
